mem_requester: RTL and testbench
================================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 fetch_req  in  1  instruction-fetch request, level, held until fetch_ack.
REQ-003 fetch_pc  in  32  fetch word address, stable while fetch_req high.
REQ-004 fetch_ack  out  1  one-cycle pulse; instr_out valid in the same cycle.
REQ-005 instr_out  out  32  registered fetched instruction, held until the next fetch completes.
REQ-006 ls_req  in  1  load/store request, level, held until ls_ack.
REQ-007 ls_we  in  1  1=store, 0=load, stable while ls_req high.
REQ-008 ls_addr  in  32  load/store word address; ls_wdata  in  32  store data.
REQ-009 ls_ack  out  1  one-cycle pulse; ls_rdata valid in the same cycle for loads.
REQ-010 ls_rdata  out  32  registered load data, held until the next load completes.
REQ-011 ReadPC  out  32  memory instruction-port address.
REQ-012 ReadWriteAddr  out  32; DataWrite  out  32  memory data-port address and store data.
REQ-013 Op2En  out  1  data-port enable; Op2RW  out  1  1=write, 0=read.
REQ-014 Instruction  in  32; Data  in  32  memory read data, valid one cycle after the address is presented.

Function
REQ-015 The FSM SHALL have states IDLE, F_ISSUE, F_CAP, LS_ISSUE, LS_CAP; all state and outputs registered.
REQ-016 In IDLE, if ls_req=1 go to LS_ISSUE; else if fetch_req=1 go to F_ISSUE; else stay (load/store has priority).
REQ-017 Fairness: after an LS_CAP, if fetch_req=1 the next grant SHALL be the fetch even if ls_req=1.
REQ-018 F_ISSUE drives ReadPC=fetch_pc for one cycle, Op2En=0; next state F_CAP.
REQ-019 F_CAP registers Instruction into instr_out, pulses fetch_ack=1, returns to IDLE.
REQ-020 LS_ISSUE drives ReadWriteAddr=ls_addr, Op2En=1, Op2RW=ls_we, DataWrite=ls_wdata for exactly one cycle; next state LS_CAP.
REQ-021 LS_CAP pulses ls_ack=1; on a load registers Data into ls_rdata; on a store ls_rdata is unchanged.
REQ-022 Latency: request sampled at edge N, ack high during cycle N+2; one transaction per 3 cycles maximum.
REQ-023 Op2En SHALL be 0 in every state except LS_ISSUE; Op2RW=0 whenever Op2En=0.
REQ-024 Requester SHALL drop req in the cycle after ack; requests are not sampled during the ack cycle (FSM is in CAP state, not IDLE).
REQ-025 Addresses SHALL pass through unmodified (word addressing, no alignment check, no wrap logic).
REQ-026 ReadPC and ReadWriteAddr SHALL hold their last driven value outside issue states.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE and all outputs (acks, Op2En, Op2RW, addresses, DataWrite, instr_out, ls_rdata) to 0.
REQ-028 Reset mid-transaction SHALL abandon it with no ack; a store in LS_ISSUE at reset assertion SHALL see Op2En drop asynchronously.
REQ-029 After rst_n rises, the first request SHALL be sampled on the first clk edge.

Configuration
REQ-030 Macro MEM_REQUESTER_COUNTERS_EN defined: add outputs fetch_cnt  out  16, load_cnt  out  16, store_cnt  out  16; each increments on its ack, saturates at 16'hFFFF, resets to 0.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 fetch_req=1, fetch_pc=0x1, Instruction=0xDEADBEEF during F_CAP -> ReadPC=0x1 at cycle 1, fetch_ack and instr_out=0xDEADBEEF at cycle 2.
REQ-033 ls_req=1, ls_we=1, ls_addr=0x2, ls_wdata=0x12345678 -> one cycle Op2En=1, Op2RW=1, DataWrite=0x12345678; ls_ack at cycle 2.
REQ-034 Load ls_addr=0x2, Data=0x12345678 -> Op2En=1, Op2RW=0 one cycle; ls_rdata=0x12345678 with ls_ack.
REQ-035 fetch_req and ls_req both held high -> grant order LS, F, LS, F; no starvation over 8 transactions.
REQ-036 rst_n low during LS_ISSUE of a store -> Op2En=0 immediately, no ls_ack, FSM IDLE after release.
REQ-037 With MEM_REQUESTER_COUNTERS_EN: 3 fetches, 2 loads, 1 store -> fetch_cnt=3, load_cnt=2, store_cnt=1.

Source files
------------

// File: rtl/mem_requester.sv
// ============================================================================
// Module   : mem_requester
// Brief    : Arbitrates instruction-fetch and load/store requests onto a
//            split instruction/data memory port; optional ack counters are
//            enabled by defining MEM_REQUESTER_COUNTERS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_requester (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ack,
    output logic [31:0] instr_out,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic [31:0] ReadPC,
    output logic [31:0] ReadWriteAddr,
    output logic [31:0] DataWrite,
    output logic        Op2En,
    output logic        Op2RW,
    input  logic [31:0] Instruction,
    input  logic [31:0] Data
`ifdef MEM_REQUESTER_COUNTERS_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] load_cnt,
    output logic [15:0] store_cnt
`endif
);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_f_issue  = 3'd1;
    localparam logic [2:0] c_f_cap    = 3'd2;
    localparam logic [2:0] c_ls_issue = 3'd3;
    localparam logic [2:0] c_ls_cap   = 3'd4;

    logic [2:0]  r_state;
    logic        r_fetch_turn;
    logic        r_fetch_ack;
    logic        r_ls_ack;
    logic [31:0] r_instr;
    logic [31:0] r_ls_rdata;
    logic [31:0] r_read_pc;
    logic [31:0] r_rw_addr;
    logic [31:0] r_data_write;
    logic        r_op2en;
    logic        r_op2rw;

    // Fetch wins over a pending load/store only right after a load/store grant.
    logic w_grant_ls;
    assign w_grant_ls = ls_req && !(r_fetch_turn && fetch_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_fetch_turn <= 1'b0;
            r_fetch_ack  <= 1'b0;
            r_ls_ack     <= 1'b0;
            r_instr      <= 32'd0;
            r_ls_rdata   <= 32'd0;
            r_read_pc    <= 32'd0;
            r_rw_addr    <= 32'd0;
            r_data_write <= 32'd0;
            r_op2en      <= 1'b0;
            r_op2rw      <= 1'b0;
        end else begin
            r_fetch_ack <= 1'b0;
            r_ls_ack    <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_grant_ls) begin
                        r_state      <= c_ls_issue;
                        r_rw_addr    <= ls_addr;
                        r_data_write <= ls_wdata;
                        r_op2en      <= 1'b1;
                        r_op2rw      <= ls_we;
                    end else if (fetch_req) begin
                        r_state   <= c_f_issue;
                        r_read_pc <= fetch_pc;
                    end
                end
                c_f_issue: begin
                    r_state      <= c_f_cap;
                    r_instr      <= Instruction;
                    r_fetch_ack  <= 1'b1;
                    r_fetch_turn <= 1'b0;
                end
                c_ls_issue: begin
                    r_state      <= c_ls_cap;
                    r_op2en      <= 1'b0;
                    r_op2rw      <= 1'b0;
                    r_ls_ack     <= 1'b1;
                    r_fetch_turn <= 1'b1;
                    if (!r_op2rw) begin
                        r_ls_rdata <= Data;
                    end
                end
                c_f_cap, c_ls_cap: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign fetch_ack     = r_fetch_ack;
    assign instr_out     = r_instr;
    assign ls_ack        = r_ls_ack;
    assign ls_rdata      = r_ls_rdata;
    assign ReadPC        = r_read_pc;
    assign ReadWriteAddr = r_rw_addr;
    assign DataWrite     = r_data_write;
    assign Op2En         = r_op2en;
    assign Op2RW         = r_op2rw;

`ifdef MEM_REQUESTER_COUNTERS_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_load_cnt;
    logic [15:0] r_store_cnt;

    // Counters step on the same edge that raises the matching ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 16'd0;
            r_load_cnt  <= 16'd0;
            r_store_cnt <= 16'd0;
        end else begin
            if (r_state == c_f_issue && r_fetch_cnt != 16'hFFFF) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (r_state == c_ls_issue && !r_op2rw && r_load_cnt != 16'hFFFF) begin
                r_load_cnt <= r_load_cnt + 16'd1;
            end
            if (r_state == c_ls_issue && r_op2rw && r_store_cnt != 16'hFFFF) begin
                r_store_cnt <= r_store_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign load_cnt  = r_load_cnt;
    assign store_cnt = r_store_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_requester.sv
// ============================================================================
// Module   : tb_mem_requester
// Brief    : Self-checking bench for mem_requester against a transaction-level
//            reference model (latency, arbitration, data capture).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_requester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ack;
    logic [31:0] instr_out;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic [31:0] ReadPC;
    logic [31:0] ReadWriteAddr;
    logic [31:0] DataWrite;
    logic        Op2En;
    logic        Op2RW;
    logic [31:0] Instruction;
    logic [31:0] Data;
`ifdef MEM_REQUESTER_COUNTERS_EN
    logic [15:0] fetch_cnt;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;
`endif

    always #5 clk = ~clk;

    mem_requester dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_req     (fetch_req),
        .fetch_pc      (fetch_pc),
        .fetch_ack     (fetch_ack),
        .instr_out     (instr_out),
        .ls_req        (ls_req),
        .ls_we         (ls_we),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_ack        (ls_ack),
        .ls_rdata      (ls_rdata),
        .ReadPC        (ReadPC),
        .ReadWriteAddr (ReadWriteAddr),
        .DataWrite     (DataWrite),
        .Op2En         (Op2En),
        .Op2RW         (Op2RW),
        .Instruction   (Instruction),
        .Data          (Data)
`ifdef MEM_REQUESTER_COUNTERS_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .load_cnt      (load_cnt),
        .store_cnt     (store_cnt)
`endif
    );

    // Memory returns the word at the currently presented address.
    logic [31:0] imem [16];
    logic [31:0] dmem [16];
    assign Instruction = imem[ReadPC[3:0]];
    assign Data        = dmem[ReadWriteAddr[3:0]];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: grant decided at the sampling edge, issue visible one
    // cycle later, ack the cycle after, next sample three edges after grant.
    int          cyc;
    int          m_next;
    int          m_gedge;
    bit          m_gls;
    bit          m_last_ls;
    bit          m_we;
    logic [31:0] m_pc, m_addr, m_wdata;
    logic [31:0] e_instr, e_rdata, e_readpc, e_rwaddr;
    int          n_f, n_ld, n_st;
    bit          hold_en, rand_en;
    int          dut_g[$];

    task automatic model_reset();
        cyc = 0; m_next = 0; m_gedge = -10; m_gls = 0; m_last_ls = 0; m_we = 0;
        m_pc = 0; m_addr = 0; m_wdata = 0;
        e_instr = 0; e_rdata = 0; e_readpc = 0; e_rwaddr = 0;
        n_f = 0; n_ld = 0; n_st = 0;
    endtask

    task automatic step();
        bit is_issue, is_ack;
        @(posedge clk);
        if (cyc >= m_next && (ls_req || fetch_req)) begin
            m_gls     = ls_req && !(m_last_ls && fetch_req);
            m_last_ls = m_gls;
            m_gedge   = cyc;
            m_next    = cyc + 3;
            if (m_gls) begin
                m_addr = ls_addr; m_we = ls_we; m_wdata = ls_wdata; e_rwaddr = ls_addr;
            end else begin
                m_pc = fetch_pc; e_readpc = fetch_pc;
            end
        end
        is_issue = (m_gedge == cyc);
        is_ack   = (m_gedge + 1 == cyc);
        if (is_ack) begin
            if (!m_gls) begin
                e_instr = imem[m_pc[3:0]]; n_f++;
            end else if (!m_we) begin
                e_rdata = dmem[m_addr[3:0]]; n_ld++;
            end else begin
                n_st++;
            end
        end
        #1;
        check("fetch_ack", fetch_ack, is_ack && !m_gls);
        check("ls_ack", ls_ack, is_ack && m_gls);
        check("Op2En", Op2En, is_issue && m_gls);
        check("Op2RW", Op2RW, is_issue && m_gls && m_we);
        check("ReadPC", ReadPC, e_readpc);
        check("ReadWriteAddr", ReadWriteAddr, e_rwaddr);
        if (is_issue && m_gls) check("DataWrite", DataWrite, m_wdata);
        check("instr_out", instr_out, e_instr);
        check("ls_rdata", ls_rdata, e_rdata);
        if (fetch_ack) dut_g.push_back(0);
        if (ls_ack)    dut_g.push_back(1);
        cyc++;
    endtask

    // Requester behaviour, applied at the falling edge.
    task automatic drive();
        bit drop_f, drop_l;
        drop_f = 0; drop_l = 0;
        if (!hold_en && (cyc - 1 == m_gedge + 2)) begin
            if (m_gls) begin ls_req = 0; drop_l = 1; end
            else begin fetch_req = 0; drop_f = 1; end
        end
        if (rand_en) begin
            if (!fetch_req && !drop_f && $urandom_range(0, 1) == 1) begin
                fetch_req = 1; fetch_pc = $urandom;
            end
            if (!ls_req && !drop_l && $urandom_range(0, 1) == 1) begin
                ls_req = 1; ls_we = 1'($urandom_range(0, 1));
                ls_addr = $urandom; ls_wdata = $urandom;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            @(negedge clk);
            drive();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            imem[i] = $urandom;
            dmem[i] = $urandom;
        end
        fetch_req = 0; fetch_pc = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
        hold_en = 0; rand_en = 0;
        model_reset();
        rst_n = 1;
        #2 rst_n = 0;
        #2;
        check("rst_fetch_ack", fetch_ack, 0);
        check("rst_ls_ack", ls_ack, 0);
        check("rst_Op2En", Op2En, 0);
        check("rst_Op2RW", Op2RW, 0);
        check("rst_ReadPC", ReadPC, 0);
        check("rst_ReadWriteAddr", ReadWriteAddr, 0);
        check("rst_DataWrite", DataWrite, 0);
        check("rst_instr_out", instr_out, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        run(2);

        // Directed store, load, fetch
        dmem[2] = 32'h12345678;
        imem[1] = 32'hDEADBEEF;
        ls_req = 1; ls_we = 1; ls_addr = 32'h2; ls_wdata = 32'h12345678;
        run(5);
        ls_req = 1; ls_we = 0; ls_addr = 32'h2; ls_wdata = 32'h0;
        run(5);
        check("load_rdata", ls_rdata, 32'h12345678);
        fetch_req = 1; fetch_pc = 32'h1;
        run(5);
        check("fetch_instr", instr_out, 32'hDEADBEEF);

        // Both requesters held high: expect strict alternation starting with LS
        dut_g.delete();
        fetch_req = 1; fetch_pc = 32'h0000_0007;
        ls_req = 1; ls_we = 0; ls_addr = 32'h0000_0005; ls_wdata = 32'h0;
        hold_en = 1;
        run(24);
        hold_en = 0;
        for (int i = 0; i < 8; i++)
            check("grant_order", (i < dut_g.size()) ? dut_g[i] : 2, (i % 2 == 0) ? 1 : 0);
        run(8);

        // Randomized traffic
        rand_en = 1;
        run(240);
        rand_en = 0;
        run(10);

`ifdef MEM_REQUESTER_COUNTERS_EN
        check("fetch_cnt", fetch_cnt, n_f[15:0]);
        check("load_cnt", load_cnt, n_ld[15:0]);
        check("store_cnt", store_cnt, n_st[15:0]);
`endif

        // Reset during the issue cycle of a store
        ls_req = 1; ls_we = 1; ls_addr = 32'h0000_0009; ls_wdata = 32'hCAFE_F00D;
        step();
        #2 rst_n = 0;
        #1;
        check("rst_async_Op2En", Op2En, 0);
        check("rst_async_Op2RW", Op2RW, 0);
        ls_req = 0;
        @(posedge clk);
        #1;
        check("rst_no_ls_ack", ls_ack, 0);
        check("rst_hold_ReadWriteAddr", ReadWriteAddr, 0);
        check("rst_hold_DataWrite", DataWrite, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        fetch_req = 1; fetch_pc = 32'h0000_0003;
        run(6);
        check("post_rst_instr", instr_out, imem[3]);
`ifdef MEM_REQUESTER_COUNTERS_EN
        check("post_rst_fetch_cnt", fetch_cnt, 16'd1);
        check("post_rst_store_cnt", store_cnt, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
